// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default threshold constants for the synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_WIDTH              = 32;
  localparam int DEFAULT_NUM_ENTRIES        = 8;
  localparam int DEFAULT_ALMOST_EMPTY_LEVEL = 1;

  // Occupancy runs 0..n inclusive, so it needs one more code than the depth.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port; contents are never reset.
module fifo_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with arbitrary depth and almost-full/almost-empty thresholds.
// Define SYNC_FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH              = DEFAULT_WIDTH,
  parameter int NUM_ENTRIES        = DEFAULT_NUM_ENTRIES,
  parameter int ALMOST_FULL_LEVEL  = NUM_ENTRIES - 1,
  parameter int ALMOST_EMPTY_LEVEL = DEFAULT_ALMOST_EMPTY_LEVEL
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_en,
  input  logic [WIDTH-1:0]                  write_data,
  output logic                              full,
  output logic                              almost_full,
  input  logic                              read_en,
  output logic [WIDTH-1:0]                  read_data,
  output logic                              empty,
  output logic                              almost_empty,
  output logic [cnt_width(NUM_ENTRIES)-1:0] count
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  ,
  output logic                              overflow,
  output logic                              underflow
`endif
);

  localparam int CW = cnt_width(NUM_ENTRIES);
  localparam int PW = ptr_width(NUM_ENTRIES);

  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_ENTRIES);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_ENTRIES - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push, pop;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push     = write_en && !full;
    pop      = read_en && !empty;
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Flags are sticky: once a request hits a full/empty FIFO they stay set until reset.
  always_comb begin
    overflow_d  = overflow_q  || (write_en && full);
    underflow_d = underflow_q || (read_en && empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  // A write during reset lands in storage but is unreachable once the pointers clear.
  fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (NUM_ENTRIES),
    .ADDR_W (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (write_data),
    .raddr (rd_ptr_q),
    .rdata (read_data)
  );

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 Parameter NUM_ENTRIES, default 8, storage depth; any integer >=2, power of two not required.
REQ-003 Parameter ALMOST_FULL_LEVEL, default NUM_ENTRIES-1, occupancy at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_LEVEL, default 1, occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 write_en  input  1  push request.
REQ-008 write_data  input  WIDTH  push data.
REQ-009 full  output  1  no free entry.
REQ-010 almost_full  output  1  count >= ALMOST_FULL_LEVEL.
REQ-011 read_en  input  1  pop request.
REQ-012 read_data  output  WIDTH  head entry, show-ahead (valid whenever !empty).
REQ-013 empty  output  1  no stored entry.
REQ-014 almost_empty  output  1  count <= ALMOST_EMPTY_LEVEL.
REQ-015 count  output  $clog2(NUM_ENTRIES+1)  current occupancy.
REQ-016 overflow, underflow  output  1 each  sticky error flags; present only under SYNC_FIFO_ERROR_FLAGS_EN.

Function
REQ-017 Push accepted at a rising edge iff write_en && !full; word stored at write pointer, pointer advances.
REQ-018 Pop accepted at a rising edge iff read_en && !empty; read pointer advances.
REQ-019 full/empty sampled before the edge: push while full rejected even with simultaneous pop; pop while empty ignored even with simultaneous push.
REQ-020 Pointers wrap from NUM_ENTRIES-1 to 0 (explicit compare, not modulo-2^n).
REQ-021 count: +1 push only, -1 pop only, unchanged when both or neither accepted.
REQ-022 full = (count==NUM_ENTRIES), empty = (count==0), almost flags per REQ-010/014; all decoded from registered count, no extra cycle.
REQ-023 read_data is combinational read of storage at read pointer; a word pushed at edge N is on read_data with empty low after edge N (latency 1).
REQ-024 Simultaneous accepted push and pop when count==1 leaves count 1 and read_data the new word after the edge.
REQ-025 read_data while empty is don't-care.

Reset
REQ-026 reset high at a rising edge clears pointers and count: empty=1, almost_empty=1, full=0, almost_full=0 (unless ALMOST_FULL_LEVEL==0), count=0.
REQ-027 Reset mid-operation discards all contents and overrides push/pop in that cycle; storage array is not reset.

Configuration
REQ-028 Macro SYNC_FIFO_ERROR_FLAGS_EN defined: overflow sets on write_en && full, underflow on read_en && empty, both held until reset.
REQ-029 Macro undefined: overflow/underflow ports and logic absent; rejected requests silently dropped.

Structure
REQ-030 Shared package fifo_pkg holds count-width/pointer-width helper function and default level constants.
REQ-031 Storage as sub-module fifo_ram (one synchronous write port, one asynchronous read port, WIDTH x NUM_ENTRIES).

Verification (WIDTH=8, NUM_ENTRIES=5, levels 4/1)
REQ-032 Reset, push 0x11..0x55 back-to-back -> count 1..5, almost_full at count 4, full at 5; read_data 0x11 throughout.
REQ-033 Full, push 0x66 -> rejected, count 5; with EN macro overflow=1 and stays 1 until reset.
REQ-034 Pop five -> read_data 0x11,0x22,0x33,0x44,0x55 in order, empty after fifth; pop again -> count 0, underflow=1 (macro).
REQ-035 Push 7 and pop 7 interleaved to cross wrap (pointer 4->0) -> data order preserved, no word lost.
REQ-036 Full with simultaneous push 0x77 and pop -> pop taken, push rejected, count 4; empty with simultaneous push 0x88 and pop -> count 1, read_data 0x88.
REQ-037 count 3, assert reset with write_en and read_en high -> next cycle count 0, empty 1, error flags 0.
